// File: rtl/timer_regs_pkg.sv
// Register map, control/status bit positions, command encodings and host FSM
// states for the 16-bit interval timer and its hardware Avalon-MM host.
package timer_regs_pkg;

  // Timer slave register indices
  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  // Control register bit positions
  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  // Status register bit positions
  localparam int unsigned ST_TO  = 0;
  localparam int unsigned ST_RUN = 1;

  typedef enum logic [1:0] {
    OP_CONFIG   = 2'd0,
    OP_STOP     = 2'd1,
    OP_SNAPSHOT = 2'd2,
    OP_STATUS   = 2'd3
  } cmd_op_e;

  typedef enum logic [3:0] {
    IDLE, WR_STOP, WR_PL, WR_PH, GAP, WR_CTRL,
    SNAP_WR, RD_L, RD_H, CAP_H,
    ST_RD, ST_CAP, ST_CLR, RESP
  } host_state_e;

  function automatic logic [15:0] ctrl_word(input logic start, input logic stop,
                                            input logic cont, input logic ito);
    logic [15:0] w;
    w             = '0;
    w[CTRL_START] = start;
    w[CTRL_STOP]  = stop;
    w[CTRL_CONT]  = cont;
    w[CTRL_ITO]   = ito;
    return w;
  endfunction

endpackage

// File: rtl/timer_avalon_host.sv
// Hardware Avalon-MM host for the 16-bit interval timer. Converts single-word
// fabric commands (CONFIG, STOP, SNAPSHOT, STATUS) into timer bus sequences and
// optionally auto-acknowledges timer interrupts.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_op        command handshake and opcode
//   cmd_period/cmd_continuous/cmd_irq_en  CONFIG operands
//   avm_address/chipselect/write_n/writedata/readdata  timer bus (no waitrequest,
//                                     readdata registered one cycle after address)
//   irq_in                            timer interrupt level
//   rsp_valid/rsp_data                one-cycle completion pulse and result
//   timeout_tick                      one-cycle pulse per auto-acked timeout
//   busy                              FSM not idle
module timer_avalon_host
  import timer_regs_pkg::*;
#(
  parameter int unsigned AUTO_ACK   = 1,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_period,
  input  logic        cmd_continuous,
  input  logic        cmd_irq_en,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        irq_in,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        timeout_tick,
  output logic        busy
);

  localparam logic [1:0] GAP_LOAD = (GAP_CYCLES == 0) ? 2'd0 : 2'(GAP_CYCLES - 1);

  host_state_e state_q, state_d;
  cmd_op_e     op_q;
  cmd_op_e     cmd_op_w;
  logic [31:0] period_q;
  logic        cont_sh_q, ie_sh_q;
  logic        auto_q;
  logic [1:0]  gap_q;
  logic [15:0] snap_l_q;
  logic [1:0]  status_q;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        irq_take, accept;

  assign cmd_op_w = cmd_op_e'(cmd_op);
  assign irq_take = (AUTO_ACK != 0) && irq_in && (state_q == IDLE);
  assign accept   = cmd_valid && cmd_ready;
  assign rsp_data = rsp_data_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (irq_take) state_d = ST_RD;
        else if (accept) begin
          unique case (cmd_op_w)
            OP_CONFIG:   state_d = WR_STOP;
            OP_STOP:     state_d = WR_STOP;
            OP_SNAPSHOT: state_d = SNAP_WR;
            OP_STATUS:   state_d = ST_RD;
            default:     state_d = IDLE;
          endcase
        end
      end
      // STOP shares the control-write state; it responds right after it
      WR_STOP: state_d = (op_q == OP_STOP) ? RESP : WR_PL;
      WR_PL:   state_d = WR_PH;
      WR_PH:   state_d = (GAP_CYCLES == 0) ? WR_CTRL : GAP;
      GAP:     state_d = (gap_q == 2'd0) ? WR_CTRL : GAP;
      WR_CTRL: state_d = RESP;
      SNAP_WR: state_d = RD_L;
      RD_L:    state_d = RD_H;
      RD_H:    state_d = CAP_H;
      CAP_H:   state_d = RESP;
      ST_RD:   state_d = ST_CAP;
      // A spurious auto-ack (TO already clear) returns silently
      ST_CAP:  state_d = avm_readdata[ST_TO] ? ST_CLR : (auto_q ? IDLE : RESP);
      ST_CLR:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = '0;
    avm_writedata  = '0;
    rsp_valid      = 1'b0;
    timeout_tick   = 1'b0;
    busy           = (state_q != IDLE);
    cmd_ready      = (state_q == IDLE) && !((AUTO_ACK != 0) && irq_in);
    unique case (state_q)
      WR_STOP: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_CONTROL;
        avm_writedata  = (op_q == OP_STOP) ? ctrl_word(1'b0, 1'b1, cont_sh_q, ie_sh_q)
                                           : ctrl_word(1'b0, 1'b1, 1'b0, 1'b0);
      end
      WR_PL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_PERIODL;
        avm_writedata  = period_q[15:0];
      end
      WR_PH: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_PERIODH;
        avm_writedata  = period_q[31:16];
      end
      WR_CTRL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_CONTROL;
        avm_writedata  = ctrl_word(1'b1, 1'b0, cont_sh_q, ie_sh_q);
      end
      SNAP_WR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_SNAPL;
      end
      RD_L: begin
        avm_chipselect = 1'b1;
        avm_address    = REG_SNAPL;
      end
      RD_H: begin
        avm_chipselect = 1'b1;
        avm_address    = REG_SNAPH;
      end
      ST_RD: begin
        avm_chipselect = 1'b1;
        avm_address    = REG_STATUS;
      end
      ST_CLR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_STATUS;
      end
      RESP: begin
        rsp_valid    = !auto_q;
        timeout_tick = auto_q;
      end
      default: ;
    endcase
  end

  // Response value, computed in the cycle that hands over to RESP
  always_comb begin
    rsp_data_d = '0;
    unique case (state_q)
      CAP_H:   rsp_data_d = {avm_readdata, snap_l_q};
      ST_CAP:  rsp_data_d = {30'b0, avm_readdata[1:0]};
      ST_CLR:  rsp_data_d = {30'b0, status_q};
      default: rsp_data_d = '0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= OP_CONFIG;
      period_q   <= '0;
      cont_sh_q  <= 1'b0;
      ie_sh_q    <= 1'b0;
      auto_q     <= 1'b0;
      gap_q      <= '0;
      snap_l_q   <= '0;
      status_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        op_q     <= cmd_op_w;
        period_q <= cmd_period;
        auto_q   <= 1'b0;
        // The shadow lets a later STOP keep the last configured mode bits
        if (cmd_op_w == OP_CONFIG) begin
          cont_sh_q <= cmd_continuous;
          ie_sh_q   <= cmd_irq_en;
        end
      end
      if (irq_take) auto_q <= 1'b1;
      if (state_q == WR_PH)    gap_q <= GAP_LOAD;
      else if (state_q == GAP) gap_q <= gap_q - 2'd1;
      if (state_q == RD_H)   snap_l_q <= avm_readdata;
      if (state_q == ST_CAP) status_q <= avm_readdata[1:0];
      // Auto-acks leave the last command result untouched
      if ((state_d == RESP) && !auto_q) rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_timer_avalon_host.sv
module tb_timer_avalon_host;

  localparam int unsigned GAP = 1;

  localparam logic [3:0] K_IDLE = 4'd1;
  localparam logic [3:0] K_NOP  = 4'd2;
  localparam logic [3:0] K_WR   = 4'd3;
  localparam logic [3:0] K_RD   = 4'd4;
  localparam logic [3:0] K_RSP  = 4'd5;
  localparam logic [3:0] K_TICK = 4'd6;
  localparam logic [3:0] K_BAD  = 4'd7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_period;
  logic        cmd_continuous;
  logic        cmd_irq_en;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        irq_in;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        timeout_tick;
  logic        busy;

  timer_avalon_host #(.AUTO_ACK(1), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_period(cmd_period), .cmd_continuous(cmd_continuous), .cmd_irq_en(cmd_irq_en),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .irq_in(irq_in), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .timeout_tick(timeout_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Simple register-file slave and reference state
  logic [15:0] sregs [0:7];
  logic [15:0] pend;
  logic [31:0] snap_src;
  logic        sh_cont, sh_ie;
  logic [31:0] last_rsp;
  logic [38:0] exp_q [$];
  logic        will_acc, acc_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] mk(input logic [3:0] k, input logic [2:0] a,
                                     input logic [31:0] d);
    return {k, a, d};
  endfunction

  // One-cycle summary of what the host is doing on the bus / response side
  function automatic logic [38:0] observe();
    if (rsp_valid && timeout_tick)               return mk(K_BAD, 3'd0, 32'd0);
    if (!busy) begin
      if (rsp_valid || timeout_tick || avm_chipselect) return mk(K_BAD, 3'd1, 32'd0);
      return mk(K_IDLE, 3'd0, rsp_data);
    end
    if (avm_chipselect) begin
      if (rsp_valid || timeout_tick)             return mk(K_BAD, 3'd2, 32'd0);
      if (avm_write_n)                           return mk(K_RD, avm_address, 32'd0);
      return mk(K_WR, avm_address, {16'd0, avm_writedata});
    end
    if (rsp_valid)    return mk(K_RSP, 3'd0, rsp_data);
    if (timeout_tick) return mk(K_TICK, 3'd0, rsp_data);
    return mk(K_NOP, 3'd0, rsp_data);
  endfunction

  task automatic slave_cycle();
    if (avm_chipselect) begin
      if (avm_write_n) pend = sregs[avm_address];
      else if (avm_address == 3'd0) sregs[0][0] = 1'b0;
      else if (avm_address == 3'd4) begin
        sregs[4] = snap_src[15:0];
        sregs[5] = snap_src[31:16];
      end else sregs[avm_address] = avm_writedata;
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [31:0] per, input logic cont,
                         input logic ie, input logic irq, input logic [1:0] st,
                         input logic [31:0] snap);
    logic [1:0]  s;
    logic [38:0] e;
    sregs[0] = {14'd0, st};
    snap_src = snap;
    s        = st;
    exp_q.delete();
    if (irq) begin
      exp_q.push_back(mk(K_RD, 3'd0, 32'd0));
      exp_q.push_back(mk(K_NOP, 3'd0, last_rsp));
      if (s[0]) begin
        exp_q.push_back(mk(K_WR, 3'd0, 32'd0));
        exp_q.push_back(mk(K_TICK, 3'd0, last_rsp));
        s[0] = 1'b0;
      end
      exp_q.push_back(mk(K_IDLE, 3'd0, last_rsp));
    end
    case (op)
      2'd0: begin
        sh_cont = cont;
        sh_ie   = ie;
        exp_q.push_back(mk(K_WR, 3'd1, 32'h8));
        exp_q.push_back(mk(K_WR, 3'd2, {16'd0, per[15:0]}));
        exp_q.push_back(mk(K_WR, 3'd3, {16'd0, per[31:16]}));
        for (int unsigned g = 0; g < GAP; g++) exp_q.push_back(mk(K_NOP, 3'd0, last_rsp));
        exp_q.push_back(mk(K_WR, 3'd1, {28'd0, 2'b01, cont, ie}));
        last_rsp = 32'd0;
        exp_q.push_back(mk(K_RSP, 3'd0, last_rsp));
      end
      2'd1: begin
        exp_q.push_back(mk(K_WR, 3'd1, {28'd0, 2'b10, sh_cont, sh_ie}));
        last_rsp = 32'd0;
        exp_q.push_back(mk(K_RSP, 3'd0, last_rsp));
      end
      2'd2: begin
        exp_q.push_back(mk(K_WR, 3'd4, 32'd0));
        exp_q.push_back(mk(K_RD, 3'd4, 32'd0));
        exp_q.push_back(mk(K_RD, 3'd5, 32'd0));
        exp_q.push_back(mk(K_NOP, 3'd0, last_rsp));
        last_rsp = snap;
        exp_q.push_back(mk(K_RSP, 3'd0, last_rsp));
      end
      default: begin
        exp_q.push_back(mk(K_RD, 3'd0, 32'd0));
        exp_q.push_back(mk(K_NOP, 3'd0, last_rsp));
        if (s[0]) exp_q.push_back(mk(K_WR, 3'd0, 32'd0));
        last_rsp = {30'd0, s};
        exp_q.push_back(mk(K_RSP, 3'd0, last_rsp));
      end
    endcase

    cmd_valid      = 1'b1;
    cmd_op         = op;
    cmd_period     = per;
    cmd_continuous = cont;
    cmd_irq_en     = ie;
    irq_in         = irq;
    #1;
    check("ready_vs_irq", cmd_ready, !irq);
    will_acc = cmd_ready;
    acc_seen = will_acc;
    foreach (exp_q[i]) begin
      @(negedge clk);
      avm_readdata = pend;
      if (will_acc) begin
        cmd_valid      = 1'b0;
        cmd_op         = 2'($urandom);
        cmd_period     = $urandom;
        cmd_continuous = 1'($urandom);
        cmd_irq_en     = 1'($urandom);
      end
      irq_in = 1'b0;
      e = observe();
      check($sformatf("op%0d_irq%0d_cyc%0d", op, irq, i + 1), {25'd0, e}, {25'd0, exp_q[i]});
      slave_cycle();
      #1;
      will_acc = cmd_valid && cmd_ready;
      if (will_acc) acc_seen = 1'b1;
    end
    @(negedge clk);
    avm_readdata = pend;
    cmd_valid    = 1'b0;
    check("accepted", acc_seen, 1'b1);
    check("idle_after", busy, 1'b0);
  endtask

  task automatic reset_mid();
    cmd_valid      = 1'b1;
    cmd_op         = 2'd0;
    cmd_period     = 32'h1234_5678;
    cmd_continuous = 1'b1;
    cmd_irq_en     = 1'b1;
    irq_in         = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_addr", avm_address, 3'd3);
    check("pre_reset_data", avm_writedata, 16'h1234);
    reset_n = 1'b0;
    #1;
    check("mid_rst_cs", avm_chipselect, 1'b0);
    check("mid_rst_wn", avm_write_n, 1'b1);
    check("mid_rst_addr", avm_address, 3'd0);
    check("mid_rst_wd", avm_writedata, 16'd0);
    check("mid_rst_rspv", rsp_valid, 1'b0);
    check("mid_rst_rspd", rsp_data, 32'd0);
    check("mid_rst_tick", timeout_tick, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    sh_cont  = 1'b0;
    sh_ie    = 1'b0;
    last_rsp = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("mid_rst_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    reset_n        = 1'b0;
    cmd_valid      = 1'b0;
    cmd_op         = 2'd0;
    cmd_period     = 32'd0;
    cmd_continuous = 1'b0;
    cmd_irq_en     = 1'b0;
    avm_readdata   = 16'd0;
    irq_in         = 1'b0;
    for (int i = 0; i < 8; i++) sregs[i] = 16'd0;
    pend     = 16'd0;
    snap_src = 32'd0;
    sh_cont  = 1'b0;
    sh_ie    = 1'b0;
    last_rsp = 32'd0;
    will_acc = 1'b0;
    acc_seen = 1'b0;

    #2;
    check("rst_cs", avm_chipselect, 1'b0);
    check("rst_wn", avm_write_n, 1'b1);
    check("rst_addr", avm_address, 3'd0);
    check("rst_wd", avm_writedata, 16'd0);
    check("rst_rspv", rsp_valid, 1'b0);
    check("rst_rspd", rsp_data, 32'd0);
    check("rst_tick", timeout_tick, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_ready", cmd_ready, 1'b1);

    // Directed cases
    run_cmd(2'd0, 32'd9, 1'b1, 1'b1, 1'b0, 2'b10, 32'd0);
    run_cmd(2'd3, 32'd0, 1'b0, 1'b0, 1'b0, 2'b11, 32'd0);
    run_cmd(2'd3, 32'd0, 1'b0, 1'b0, 1'b0, 2'b10, 32'd0);
    run_cmd(2'd3, 32'd0, 1'b0, 1'b0, 1'b1, 2'b01, 32'd0);
    run_cmd(2'd2, 32'd0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0001_86A0);
    run_cmd(2'd1, 32'd0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0);
    run_cmd(2'd2, 32'd0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h0001_FFFF);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      run_cmd(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              2'($urandom_range(0, 3)), $urandom);
    end

    // Abort during CONFIG, then verify shadow reset and a full CONFIG
    run_cmd(2'd2, 32'd0, 1'b0, 1'b0, 1'b0, 2'b00, 32'hDEAD_BEEF);
    reset_mid();
    run_cmd(2'd1, 32'd0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0);
    run_cmd(2'd0, 32'hABCD_0123, 1'b0, 1'b1, 1'b0, 2'b00, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
